// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and memory-serializer state encoding.
package cpu_types_pkg;

   localparam int unsigned WORD_BITS = 32;

   typedef logic [WORD_BITS-1:0] word_t;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} vms_state_t;

   typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} vms_op_t;

endpackage

// File: rtl/vector_load_buffer.sv
// Per-thread load result registers with a single indexed write port.
module vector_load_buffer #(
   parameter int unsigned THREADS = 4,
   parameter int unsigned WORD_W  = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             we,
   input  logic [$clog2(THREADS)-1:0]       idx,
   input  logic [WORD_W-1:0]                wdata,
   output logic [THREADS-1:0][WORD_W-1:0]   vdload
);

   logic [THREADS-1:0][WORD_W-1:0] vdload_q, vdload_d;

   always_comb begin
      vdload_d = vdload_q;
      if (we) vdload_d[idx] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vdload_q <= '0;
      else        vdload_q <= vdload_d;
   end

   assign vdload = vdload_q;

endmodule

// File: rtl/vector_mem_serializer.sv
// Serializes one scalar or THREADS-wide vector load/store into single-word cache accesses.
// Optional macro VECTOR_MEM_SERIALIZER_COALESCE_EN skips vector-read lanes repeating the previous address.
module vector_mem_serializer
   import cpu_types_pkg::*;
#(
   parameter int unsigned THREADS = 4,
   parameter int unsigned WORD_W  = 32
) (
   input  logic                           CLK,
   input  logic                           nRST,
   input  logic                           readReq,
   input  logic                           writeReq,
   input  logic                           isVector,
   input  logic [THREADS-1:0][WORD_W-1:0] vdaddr,
   input  logic [THREADS-1:0][WORD_W-1:0] vdstore,
   input  logic [WORD_W-1:0]              sdaddr,
   input  logic [WORD_W-1:0]              sdstore,
   output logic                           dHit,
   output logic                           busy,
   output logic [THREADS-1:0][WORD_W-1:0] vdload,
   output logic [WORD_W-1:0]              sdload,
   output logic                           dmemREN,
   output logic                           dmemWEN,
   output logic [WORD_W-1:0]              dmemaddr,
   output logic [WORD_W-1:0]              dmemstore,
   input  logic [WORD_W-1:0]              dmemload,
   input  logic                           dcacheHit
);

   localparam int unsigned IDX_W = $clog2(THREADS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(THREADS - 1);

   typedef logic [IDX_W-1:0] idx_t;

   vms_state_t state_q, state_d;
   idx_t       idx_q, idx_d;
   vms_op_t    op_q, op_d;
   logic       vec_q, vec_d;
   logic [THREADS-1:0][WORD_W-1:0] vaddr_q, vaddr_d, vdata_q, vdata_d;
   logic [WORD_W-1:0] saddr_q, saddr_d, sdata_q, sdata_d;
   logic [WORD_W-1:0] sdload_q, sdload_d, addr_q, addr_d, store_q, store_d;
   logic dhit_q, dhit_d, busy_q, busy_d, ren_q, ren_d, wen_q, wen_d;

   logic              lb_we;
   logic [WORD_W-1:0] lb_wdata;
   logic [THREADS-1:0] coal_lane_c;
   logic              coal_cur;
   logic              step;

   // Lanes of a latched vector read whose address repeats the previous lane
   always_comb begin
      coal_lane_c = '0;
`ifdef VECTOR_MEM_SERIALIZER_COALESCE_EN
      for (int unsigned i = 1; i < THREADS; i++)
         coal_lane_c[i] = vec_q && (op_q == OP_READ) && (vaddr_q[i] == vaddr_q[i-1]);
`else
      coal_lane_c = '0;
`endif
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      op_d     = op_q;
      vec_d    = vec_q;
      vaddr_d  = vaddr_q;
      vdata_d  = vdata_q;
      saddr_d  = saddr_q;
      sdata_d  = sdata_q;
      sdload_d = sdload_q;
      addr_d   = addr_q;
      store_d  = store_q;
      lb_we    = 1'b0;
      lb_wdata = dmemload;
      coal_cur = (state_q == ACCESS) && coal_lane_c[idx_q];
      step     = coal_cur || dcacheHit;

      unique case (state_q)
         IDLE: begin
            if (readReq || writeReq) begin
               op_d    = readReq ? OP_READ : OP_WRITE;
               vec_d   = isVector;
               vaddr_d = vdaddr;
               vdata_d = vdstore;
               saddr_d = sdaddr;
               sdata_d = sdstore;
               idx_d   = '0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (step) begin
               if (op_q == OP_READ) begin
                  if (vec_q) begin
                     lb_we    = 1'b1;
                     lb_wdata = coal_cur ? vdload[idx_q - IDX_W'(1)] : dmemload;
                  end else begin
                     sdload_d = dmemload;
                  end
               end
               if (!vec_q || idx_q == LAST_IDX) state_d = DONE;
               else                             idx_d   = idx_q + IDX_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Cache-side outputs are registered, so derive them from the next state
      dhit_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
      ren_d  = 1'b0;
      wen_d  = 1'b0;
      if (state_d == ACCESS && !coal_lane_c[idx_d]) begin
         ren_d   = (op_d == OP_READ);
         wen_d   = (op_d == OP_WRITE);
         addr_d  = vec_d ? vaddr_d[idx_d] : saddr_d;
         store_d = vec_d ? vdata_d[idx_d] : sdata_d;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         op_q     <= OP_READ;
         vec_q    <= 1'b0;
         vaddr_q  <= '0;
         vdata_q  <= '0;
         saddr_q  <= '0;
         sdata_q  <= '0;
         sdload_q <= '0;
         addr_q   <= '0;
         store_q  <= '0;
         dhit_q   <= 1'b0;
         busy_q   <= 1'b0;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         op_q     <= op_d;
         vec_q    <= vec_d;
         vaddr_q  <= vaddr_d;
         vdata_q  <= vdata_d;
         saddr_q  <= saddr_d;
         sdata_q  <= sdata_d;
         sdload_q <= sdload_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         dhit_q   <= dhit_d;
         busy_q   <= busy_d;
         ren_q    <= ren_d;
         wen_q    <= wen_d;
      end
   end

   vector_load_buffer #(
      .THREADS (THREADS),
      .WORD_W  (WORD_W)
   ) u_load_buf (
      .clk    (CLK),
      .rst_n  (nRST),
      .we     (lb_we),
      .idx    (idx_q),
      .wdata  (lb_wdata),
      .vdload (vdload)
   );

   assign dHit      = dhit_q;
   assign busy      = busy_q;
   assign sdload    = sdload_q;
   assign dmemREN   = ren_q;
   assign dmemWEN   = wen_q;
   assign dmemaddr  = addr_q;
   assign dmemstore = store_q;

endmodule
